// File: rtl/div_iter_pkg.sv
// Shared constants, state encoding and operand helpers for the iterative divider.
package div_iter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

   localparam int          DIV_CYCLES    = 32;
   localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

   // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (-v) : v;
   endfunction

   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic do_neg);
      return do_neg ? (-v) : v;
   endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative 32-cycle restoring divider (div/divu) for the EX stage.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |divisor| > |dividend|.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic             flush,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             ready,
   output logic             busy,
   output logic             stallreq,
   output logic [1:0]       state_dbg
);

   div_state_t           state;
   logic [5:0]           count;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     dvsr;
   logic                 sgn_op;
   logic                 q_neg;
   logic                 r_neg;

   logic [WIDTH-1:0]     dvd_mag;
   logic [WIDTH-1:0]     dvs_mag;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH:0]       rem_sub;
   logic [2*WIDTH-1:0]   acc_nxt;
   logic [WIDTH-1:0]     q_fix;
   logic [WIDTH-1:0]     r_fix;

   assign dvd_mag = abs32(dividend, signed_op);
   assign dvs_mag = abs32(divisor, signed_op);

   // Partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits
   // and bit WIDTH of the difference is a clean borrow flag.
   always_comb begin
      rem_sh  = acc[2*WIDTH-1:WIDTH-1];
      rem_sub = rem_sh - {1'b0, dvsr};
      acc_nxt = '0;
      if (!rem_sub[WIDTH]) begin
         acc_nxt = {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

   assign q_fix = neg_if(acc_nxt[WIDTH-1:0], sgn_op & q_neg);
   assign r_fix = neg_if(acc_nxt[2*WIDTH-1:WIDTH], sgn_op & r_neg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         count     <= '0;
         acc       <= '0;
         dvsr      <= '0;
         sgn_op    <= 1'b0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sgn_op <= signed_op;
                  q_neg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_neg  <= dividend[WIDTH-1];
                  dvsr   <= dvs_mag;
                  acc    <= {{WIDTH{1'b0}}, dvd_mag};
                  count  <= '0;
                  if (divisor == '0) begin
                     quotient  <= DIV_ZERO_QUOT;
                     remainder <= dividend;
                     state     <= ST_DONE;
                  end
`ifdef DIV_EARLY_OUT_EN
                  else if (dvs_mag > dvd_mag) begin
                     quotient  <= '0;
                     remainder <= dividend;
                     state     <= ST_DONE;
                  end
`endif
                  else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               acc   <= acc_nxt;
               count <= count + 6'd1;
               if (count == 6'(DIV_CYCLES - 1)) begin
                  quotient  <= q_fix;
                  remainder <= r_fix;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ready     = (state == ST_DONE) & ~flush;
   assign busy      = (state != ST_IDLE);
   assign stallreq  = (start & (state == ST_IDLE) & ~flush) | (state == ST_RUN);
   assign state_dbg = state;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus randomized operands
// compared against an arithmetic reference model.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_op;
   logic        flush;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        ready;
   logic        busy;
   logic        stallreq;
   logic [1:0]  state_dbg;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q[$];

   div_iter #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .signed_op (signed_op),
      .flush     (flush),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .ready     (ready),
      .busy      (busy),
      .stallreq  (stallreq),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   // Reference: plain 64-bit integer division, truncated to 32 bits.
   function automatic logic [63:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint na, nb, q, r;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (s) begin
         na = longint'($signed(a));
         nb = longint'($signed(b));
      end else begin
         na = longint'({32'd0, a});
         nb = longint'({32'd0, b});
      end
      q = na / nb;
      r = na % nb;
      return {q[31:0], r[31:0]};
   endfunction

   function automatic longint mag(input logic [31:0] v, input logic s);
      longint n;
      n = s ? longint'($signed(v)) : longint'({32'd0, v});
      return (n < 0) ? -n : n;
   endfunction

   function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b, input logic s);
      if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
      if (mag(b, s) > mag(a, s)) return 1;
`else
      if (mag(b, s) < 0) return 0;
`endif
      return 33;
   endfunction

   // Issues one divide; returns result, cycles from start to ready, and stallreq behaviour.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input bit hold,
                          output logic [31:0] q, output logic [31:0] r, output int lat,
                          output int stall_hi, output logic stall_done);
      @(negedge clk);
      dividend  = a;
      divisor   = b;
      signed_op = s;
      start     = 1'b1;
      #1;
      stall_hi   = stallreq ? 1 : 0;
      lat        = -1;
      stall_done = 1'bx;
      q          = 'x;
      r          = 'x;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (hold) begin
            dividend  = $urandom;
            divisor   = 32'($urandom_range(1, 9));
            signed_op = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b0;
         end
         #1;
         if (ready) begin
            lat        = c;
            q          = quotient;
            r          = remainder;
            stall_done = stallreq;
            break;
         end else if (stallreq) begin
            stall_hi++;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({quotient, remainder, ready, busy, stallreq} !== 67'd0) begin
         bad++;
         $display("FAIL reset_outputs got q=%h r=%h rdy=%b busy=%b stall=%b exp all 0",
                  quotient, remainder, ready, busy, stallreq);
      end
      rst = 1'b0;
   endtask

   task automatic test_unsigned();
      logic [31:0] q, r;
      int lat, sh;
      logic sd;
      run_div(32'd100, 32'd7, 1'b0, 1'b0, q, r, lat, sh, sd);
      total++; if (q !== 32'd14) begin bad++; $display("FAIL u100_7_q got=%h exp=%h", q, 32'd14); end
      total++; if (r !== 32'd2) begin bad++; $display("FAIL u100_7_r got=%h exp=%h", r, 32'd2); end
      total++; if (lat != 33) begin bad++; $display("FAIL u100_7_latency got=%0d exp=33", lat); end
      total++; if (sh != 33) begin bad++; $display("FAIL u100_7_stall_cycles got=%0d exp=33", sh); end
      total++; if (sd !== 1'b0) begin bad++; $display("FAIL u100_7_stall_in_done got=%b exp=0", sd); end
   endtask

   task automatic test_signed();
      logic [31:0] q, r;
      int lat, sh;
      logic sd;
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, q, r, lat, sh, sd);
      total++; if (q !== 32'hFFFF_FFFD) begin bad++; $display("FAIL s_m7_2_q got=%h exp=fffffffd", q); end
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL s_m7_2_r got=%h exp=ffffffff", r); end
      run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, q, r, lat, sh, sd);
      total++; if (q !== 32'h7FFF_FFFC) begin bad++; $display("FAIL u_fff9_2_q got=%h exp=7ffffffc", q); end
      total++; if (r !== 32'd1) begin bad++; $display("FAIL u_fff9_2_r got=%h exp=1", r); end
   endtask

   task automatic test_overflow_and_zero();
      logic [31:0] q, r;
      int lat, sh;
      logic sd;
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, q, r, lat, sh, sd);
      total++; if (q !== 32'h8000_0000) begin bad++; $display("FAIL ovf_q got=%h exp=80000000", q); end
      total++; if (r !== 32'd0) begin bad++; $display("FAIL ovf_r got=%h exp=0", r); end
      run_div(32'd5, 32'd0, 1'b0, 1'b0, q, r, lat, sh, sd);
      total++; if (q !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_q got=%h exp=ffffffff", q); end
      total++; if (r !== 32'd5) begin bad++; $display("FAIL div0_r got=%h exp=5", r); end
      total++; if (lat != 1) begin bad++; $display("FAIL div0_latency got=%0d exp=1", lat); end
      total++; if (sd !== 1'b0) begin bad++; $display("FAIL div0_stall_in_done got=%b exp=0", sd); end
   endtask

   task automatic test_flush();
      logic [31:0] q, r;
      int lat, sh, seen;
      logic sd;
      @(negedge clk);
      dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1;
      total++; if ({ready, busy} !== 2'b01) begin bad++; $display("FAIL flush_run_cycle got rdy=%b busy=%b exp rdy=0 busy=1", ready, busy); end
      @(negedge clk);
      flush = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy_next got=%b exp=0", busy); end
      seen = 0;
      repeat (40) begin @(negedge clk); #1; if (ready) seen++; end
      total++; if (seen != 0) begin bad++; $display("FAIL flush_no_ready got=%0d pulses exp=0", seen); end
      run_div(32'd20, 32'd3, 1'b0, 1'b0, q, r, lat, sh, sd);
      total++; if ({q, r} !== {32'd6, 32'd2}) begin bad++; $display("FAIL after_flush_20_3 got q=%h r=%h exp q=6 r=2", q, r); end
      total++; if (lat != 33) begin bad++; $display("FAIL after_flush_latency got=%0d exp=33", lat); end
      // Flush landing on the DONE cycle must swallow the ready pulse.
      @(negedge clk);
      dividend = 32'd5; divisor = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b1;
      #1;
      total++; if ({ready, busy} !== 2'b01) begin bad++; $display("FAIL flush_done got rdy=%b busy=%b exp rdy=0 busy=1", ready, busy); end
      @(negedge clk);
      flush = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_done_busy got=%b exp=0", busy); end
      // Flush beats start in the same IDLE cycle.
      @(negedge clk);
      dividend = 32'd9; divisor = 32'd7; start = 1'b1; flush = 1'b1;
      #1;
      total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL flush_start_stall got=%b exp=0", stallreq); end
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy got=%b exp=0", busy); end
   endtask

   task automatic test_early_out();
      logic [31:0] q, r;
      int lat, sh, exp_lat;
      logic sd;
`ifdef DIV_EARLY_OUT_EN
      exp_lat = 1;
`else
      exp_lat = 33;
`endif
      run_div(32'd3, 32'd10, 1'b0, 1'b0, q, r, lat, sh, sd);
      total++; if ({q, r} !== {32'd0, 32'd3}) begin bad++; $display("FAIL small_3_10 got q=%h r=%h exp q=0 r=3", q, r); end
      total++; if (lat != exp_lat) begin bad++; $display("FAIL small_3_10_latency got=%0d exp=%0d", lat, exp_lat); end
   endtask

   task automatic test_reset_mid_run();
      int seen;
      @(negedge clk);
      dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({quotient, remainder, ready, busy, stallreq} !== 67'd0) begin
         bad++;
         $display("FAIL reset_mid_run got q=%h r=%h rdy=%b busy=%b stall=%b exp all 0",
                  quotient, remainder, ready, busy, stallreq);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (40) begin @(negedge clk); #1; if (ready || busy) seen++; end
      total++; if (seen != 0) begin bad++; $display("FAIL reset_no_ready got=%0d active cycles exp=0", seen); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q, r;
      int lat, sh;
      logic sd;
      run_div(32'd100, 32'd7, 1'b0, 1'b1, q, r, lat, sh, sd);
      total++; if ({q, r} !== {32'd14, 32'd2}) begin bad++; $display("FAIL start_held got q=%h r=%h exp q=e r=2", q, r); end
      total++; if (lat != 33) begin bad++; $display("FAIL start_held_latency got=%0d exp=33", lat); end
      @(negedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_held_idle got busy=%b exp=0", busy); end
   endtask

   task automatic test_random();
      logic [31:0] a, b, q, r;
      logic s;
      logic [63:0] e;
      int lat, sh, exp_lat;
      logic sd;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: b = 32'($urandom_range(0, 15));
            1: b = $urandom;
            2: b = a >> $urandom_range(0, 31);
            default: b = -32'($urandom_range(1, 300));
         endcase
         exp_q.push_back(ref_result(a, b, s));
         exp_lat = ref_latency(a, b, s);
         run_div(a, b, s, 1'b0, q, r, lat, sh, sd);
         e = exp_q.pop_front();
         total++;
         if ({q, r} !== e) begin
            bad++;
            $display("FAIL rand_result a=%h b=%h s=%b got q=%h r=%h exp q=%h r=%h", a, b, s, q, r, e[63:32], e[31:0]);
         end
         total++;
         if (lat != exp_lat) begin
            bad++;
            $display("FAIL rand_latency a=%h b=%h s=%b got=%0d exp=%0d", a, b, s, lat, exp_lat);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      signed_op = 1'b0;
      flush     = 1'b0;
      dividend  = '0;
      divisor   = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_overflow_and_zero();
      test_flush();
      test_early_out();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
